// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
//   Instruction-fetch / program-counter stage in front of the single-cycle
//   decoder. Fetches one word per instruction over a req/ready handshake,
//   holds it in the instruction register, and selects the next PC from the
//   decoder AddrSelector and the ALU branch flags.
//
// Ports
//   clk, rstN                       clock, async active-low reset
//   startIn                         leave IDLE and begin fetching
//   imemReqOut/imemAddrOut          fetch request and word address
//   imemReadyIn/imemDataIn          fetch completion and instruction word
//   instrOut/opcodeOut              instruction register and its [4:0] field
//   instrValidOut                   high in EXEC (decoder outputs valid)
//   addrSelIn, ltFlagIn, zeroFlagIn next-PC selector and branch flags
//   immIn, regIn                    branch/jump offset, jalr base register
//   stallIn                         hold EXEC
//   pcOut, linkOut                  current PC, PC+1 link value
//   retiredOut                      retired-instruction count
//   haltedOut                       high in HALT
//   illegalSelOut                   pulse after a reserved selector retires
module fetch_pc_unit #(
  parameter int unsigned     PC_WIDTH    = 16,
  parameter int unsigned     INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [4:0]      HALT_OPCODE = 5'b11111,
  parameter int unsigned     CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   startIn,
  output logic                   imemReqOut,
  output logic [PC_WIDTH-1:0]    imemAddrOut,
  input  logic                   imemReadyIn,
  input  logic [INSTR_WIDTH-1:0] imemDataIn,
  output logic [INSTR_WIDTH-1:0] instrOut,
  output logic [4:0]             opcodeOut,
  output logic                   instrValidOut,
  input  logic [2:0]             addrSelIn,
  input  logic                   ltFlagIn,
  input  logic                   zeroFlagIn,
  input  logic [PC_WIDTH-1:0]    immIn,
  input  logic [PC_WIDTH-1:0]    regIn,
  input  logic                   stallIn,
  output logic [PC_WIDTH-1:0]    pcOut,
  output logic [PC_WIDTH-1:0]    linkOut,
  output logic [CNT_WIDTH-1:0]   retiredOut,
  output logic                   haltedOut,
  output logic                   illegalSelOut
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [CNT_WIDTH-1:0]   retired_q, retired_d;
  logic                   illegal_q, illegal_d;
  logic                   req_q, req_d;
  logic                   valid_q, valid_d;
  logic                   halted_q, halted_d;

  logic [PC_WIDTH-1:0]    pc_plus1;
  logic [PC_WIDTH-1:0]    pc_rel;
  logic [PC_WIDTH-1:0]    next_pc;

  // Next-PC selection; all arithmetic wraps modulo 2^PC_WIDTH.
  always_comb begin
    pc_plus1 = pc_q + PC_WIDTH'(1);
    pc_rel   = pc_q + immIn;
    next_pc  = pc_plus1;
    case (addrSelIn)
      3'b001:  next_pc = ltFlagIn   ? pc_rel : pc_plus1;
      3'b010:  next_pc = zeroFlagIn ? pc_rel : pc_plus1;
      3'b011:  next_pc = pc_rel;
      3'b100:  next_pc = regIn + immIn;
      default: next_pc = pc_plus1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    illegal_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (startIn) state_d = FETCH;
      end
      FETCH: begin
        if (imemReadyIn) begin
          instr_d = imemDataIn;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!stallIn) begin
          pc_d      = next_pc;
          retired_d = retired_q + CNT_WIDTH'(1);
          illegal_d = (addrSelIn >= 3'd5);
          state_d   = (instr_q[4:0] == HALT_OPCODE) ? HALT : FETCH;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: state_d = IDLE;
    endcase
    // Handshake/status outputs are registered copies of the next-state decode.
    req_d    = (state_d == FETCH);
    valid_d  = (state_d == EXEC);
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
    end
  end

  assign imemReqOut    = req_q;
  assign imemAddrOut   = pc_q;
  assign instrOut      = instr_q;
  assign opcodeOut     = instr_q[4:0];
  assign instrValidOut = valid_q;
  assign pcOut         = pc_q;
  assign linkOut       = pc_plus1;
  assign retiredOut    = retired_q;
  assign haltedOut     = halted_q;
  assign illegalSelOut = illegal_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, branches, jumps,
// fetch wait states and stalls, PC wrap, reserved selectors, halt and reset.
`timescale 1ns/1ps
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rstN;
  logic        startIn;
  logic        imemReqOut;
  logic [15:0] imemAddrOut;
  logic        imemReadyIn;
  logic [31:0] imemDataIn;
  logic [31:0] instrOut;
  logic [4:0]  opcodeOut;
  logic        instrValidOut;
  logic [2:0]  addrSelIn;
  logic        ltFlagIn;
  logic        zeroFlagIn;
  logic [15:0] immIn;
  logic [15:0] regIn;
  logic        stallIn;
  logic [15:0] pcOut;
  logic [15:0] linkOut;
  logic [31:0] retiredOut;
  logic        haltedOut;
  logic        illegalSelOut;

  int passed = 0;
  int total  = 0;

  localparam logic [31:0] ADDI = 32'h0010_0013;
  localparam logic [31:0] HLT  = 32'h0000_001F;

  fetch_pc_unit #(
    .PC_WIDTH(16), .INSTR_WIDTH(32), .RESET_PC(16'h0000),
    .HALT_OPCODE(5'b11111), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rstN(rstN), .startIn(startIn),
    .imemReqOut(imemReqOut), .imemAddrOut(imemAddrOut),
    .imemReadyIn(imemReadyIn), .imemDataIn(imemDataIn),
    .instrOut(instrOut), .opcodeOut(opcodeOut), .instrValidOut(instrValidOut),
    .addrSelIn(addrSelIn), .ltFlagIn(ltFlagIn), .zeroFlagIn(zeroFlagIn),
    .immIn(immIn), .regIn(regIn), .stallIn(stallIn),
    .pcOut(pcOut), .linkOut(linkOut), .retiredOut(retiredOut),
    .haltedOut(haltedOut), .illegalSelOut(illegalSelOut)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a fetch request, optionally inserts wait states,
  // then completes it with the given word. Reports cycles waited and address.
  task automatic fetch_word(input logic [31:0] word, input int delay,
                            output int waited, output logic [15:0] addr);
    waited = 0;
    while (!imemReqOut && waited < 20) begin
      step();
      waited++;
    end
    addr = imemAddrOut;
    repeat (delay) step();
    imemReadyIn = 1'b1;
    imemDataIn  = word;
    step();
    imemReadyIn = 1'b0;
    imemDataIn  = 32'hDEAD_BEEF;
  endtask

  task automatic retire(input logic [2:0] sel, input logic [15:0] imm,
                        input logic [15:0] rg, input logic lt, input logic zr);
    addrSelIn = sel; immIn = imm; regIn = rg; ltFlagIn = lt; zeroFlagIn = zr;
    stallIn = 1'b0;
    step();
    addrSelIn = 3'b000; immIn = '0; regIn = '0; ltFlagIn = 1'b0; zeroFlagIn = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0; startIn = 1'b0; imemReadyIn = 1'b0; imemDataIn = '0;
    addrSelIn = '0; ltFlagIn = 1'b0; zeroFlagIn = 1'b0; immIn = '0;
    regIn = '0; stallIn = 1'b0;
    step(); step();
    total++;
    if ({pcOut, instrOut, retiredOut} !== {16'h0000, 32'h0, 32'h0}) begin
      $display("FAIL reset_regs pc=%h instr=%h ret=%0d want 0/0/0", pcOut, instrOut, retiredOut);
    end else passed++;
    total++;
    if ({imemReqOut, instrValidOut, haltedOut, illegalSelOut} !== 4'b0000) begin
      $display("FAIL reset_flags req/valid/halt/ill=%b want 0000",
               {imemReqOut, instrValidOut, haltedOut, illegalSelOut});
    end else passed++;
    rstN = 1'b1;
    step();
    total++;
    if (imemReqOut !== 1'b0) $display("FAIL idle_no_req req=%b want 0", imemReqOut);
    else passed++;
  endtask

  task automatic test_sequential();
    int w; logic [15:0] a;
    startIn = 1'b1; step(); startIn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fetch_word(ADDI + 32'(i << 8), 0, w, a);
      total++;
      if (a !== 16'(i) || w != 0) $display("FAIL seq_addr%0d addr=%h wait=%0d want %h/0", i, a, w, i);
      else passed++;
      if (i == 2) begin
        total++;
        if (instrOut !== ADDI + 32'h200 || instrValidOut !== 1'b1 || opcodeOut !== 5'h13)
          $display("FAIL seq_instr instr=%h valid=%b op=%h want %h/1/13", instrOut, instrValidOut, opcodeOut, ADDI + 32'h200);
        else passed++;
      end
      retire(3'b000, 16'h0, 16'h0, 1'b1, 1'b1);
    end
    total++;
    if (retiredOut !== 32'd4 || pcOut !== 16'd4)
      $display("FAIL seq_retired ret=%0d pc=%h want 4/0004", retiredOut, pcOut);
    else passed++;
  endtask

  task automatic test_branch();
    int w; logic [15:0] a;
    fetch_word(ADDI, 0, w, a); retire(3'b011, 16'd6, 16'h0, 1'b0, 1'b0); // 4 -> 10
    fetch_word(ADDI, 0, w, a);
    total++;
    if (a !== 16'd10) $display("FAIL jal_to_10 addr=%h want 000a", a); else passed++;
    retire(3'b001, 16'hFFFC, 16'h0, 1'b1, 1'b0);                         // blt taken
    fetch_word(ADDI, 0, w, a);
    total++;
    if (a !== 16'd6) $display("FAIL blt_taken addr=%h want 0006", a); else passed++;
    retire(3'b011, 16'd4, 16'h0, 1'b0, 1'b0);                            // 6 -> 10
    fetch_word(ADDI, 0, w, a);
    retire(3'b001, 16'hFFFC, 16'h0, 1'b0, 1'b1);                         // blt not taken
    fetch_word(ADDI, 0, w, a);
    total++;
    if (a !== 16'd11) $display("FAIL blt_not_taken addr=%h want 000b", a); else passed++;
    retire(3'b010, 16'd9, 16'h0, 1'b0, 1'b1);                            // beq taken
    total++;
    if (pcOut !== 16'd20) $display("FAIL beq_taken pc=%h want 0014", pcOut); else passed++;
  endtask

  task automatic test_jump();
    int w; logic [15:0] a;
    fetch_word(ADDI, 0, w, a);
    total++;
    if (linkOut !== 16'd21) $display("FAIL jal_link link=%h want 0015", linkOut); else passed++;
    retire(3'b011, 16'd5, 16'h0, 1'b1, 1'b1);
    total++;
    if (pcOut !== 16'd25) $display("FAIL jal_pc pc=%h want 0019", pcOut); else passed++;
    fetch_word(ADDI, 0, w, a);
    retire(3'b100, 16'd2, 16'h0100, 1'b1, 1'b1);
    total++;
    if (pcOut !== 16'h0102) $display("FAIL jalr_pc pc=%h want 0102", pcOut); else passed++;
  endtask

  task automatic test_stall();
    int w; logic [15:0] a; logic [15:0] p0; logic [31:0] i0, r0;
    fetch_word(32'h0000_5513, 3, w, a);
    total++;
    if (a !== 16'h0102 || instrOut !== 32'h0000_5513 || instrValidOut !== 1'b1)
      $display("FAIL slow_fetch addr=%h instr=%h valid=%b want 0102/00005513/1", a, instrOut, instrValidOut);
    else passed++;
    p0 = pcOut; i0 = instrOut; r0 = retiredOut;
    stallIn = 1'b1; addrSelIn = 3'b011; immIn = 16'h0040;
    imemReadyIn = 1'b1; imemDataIn = 32'hBAD0_0013;
    for (int c = 0; c < 2; c++) begin
      step();
      total++;
      if (pcOut !== p0 || instrOut !== i0 || retiredOut !== r0 || instrValidOut !== 1'b1)
        $display("FAIL stall_hold%0d pc=%h instr=%h ret=%0d valid=%b want %h/%h/%0d/1",
                 c, pcOut, instrOut, retiredOut, instrValidOut, p0, i0, r0);
      else passed++;
    end
    imemReadyIn = 1'b0;
    retire(3'b000, 16'h0, 16'h0, 1'b0, 1'b0);
    total++;
    if (retiredOut !== r0 + 32'd1 || pcOut !== 16'h0103)
      $display("FAIL stall_retire ret=%0d pc=%h want %0d/0103", retiredOut, pcOut, r0 + 32'd1);
    else passed++;
  endtask

  task automatic test_wrap_illegal();
    int w; logic [15:0] a;
    fetch_word(ADDI, 0, w, a);
    retire(3'b100, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
    fetch_word(ADDI, 0, w, a);
    total++;
    if (a !== 16'hFFFF || linkOut !== 16'h0000)
      $display("FAIL wrap_link addr=%h link=%h want ffff/0000", a, linkOut);
    else passed++;
    retire(3'b000, 16'h0, 16'h0, 1'b0, 1'b0);
    total++;
    if (pcOut !== 16'h0000 || illegalSelOut !== 1'b0)
      $display("FAIL wrap_pc pc=%h ill=%b want 0000/0", pcOut, illegalSelOut);
    else passed++;
    fetch_word(ADDI, 0, w, a);
    retire(3'b101, 16'd9, 16'h0, 1'b1, 1'b1);
    total++;
    if (pcOut !== 16'h0001 || illegalSelOut !== 1'b1)
      $display("FAIL illegal_sel pc=%h ill=%b want 0001/1", pcOut, illegalSelOut);
    else passed++;
    step();
    total++;
    if (illegalSelOut !== 1'b0) $display("FAIL illegal_pulse ill=%b want 0", illegalSelOut);
    else passed++;
  endtask

  task automatic test_halt();
    int w; logic [15:0] a; logic seen;
    fetch_word(HLT, 0, w, a);
    retire(3'b000, 16'h0, 16'h0, 1'b0, 1'b0);
    total++;
    if (haltedOut !== 1'b1 || imemReqOut !== 1'b0 || pcOut !== 16'h0002)
      $display("FAIL halt_enter halted=%b req=%b pc=%h want 1/0/0002", haltedOut, imemReqOut, pcOut);
    else passed++;
    seen = 1'b0;
    startIn = 1'b1;
    repeat (4) begin
      step();
      if (imemReqOut !== 1'b0 || haltedOut !== 1'b1) seen = 1'b1;
    end
    startIn = 1'b0;
    total++;
    if (seen !== 1'b0) $display("FAIL halt_sticky left_halt=%b want 0", seen);
    else passed++;
  endtask

  task automatic test_reset_midfetch();
    int w; logic [15:0] a;
    rstN = 1'b0; step(); rstN = 1'b1;
    startIn = 1'b1; step(); startIn = 1'b0;
    fetch_word(ADDI, 0, w, a);
    retire(3'b011, 16'd7, 16'h0, 1'b0, 1'b0);
    step();
    total++;
    if (imemReqOut !== 1'b1 || pcOut !== 16'd7)
      $display("FAIL pre_reset req=%b pc=%h want 1/0007", imemReqOut, pcOut);
    else passed++;
    #2 rstN = 1'b0;
    #1;
    total++;
    if ({imemReqOut, instrValidOut, haltedOut} !== 3'b000 || pcOut !== 16'h0000 ||
        retiredOut !== 32'd0 || instrOut !== 32'd0)
      $display("FAIL async_reset req/valid/halt=%b pc=%h ret=%0d instr=%h want 000/0000/0/0",
               {imemReqOut, instrValidOut, haltedOut}, pcOut, retiredOut, instrOut);
    else passed++;
    step();
    rstN = 1'b1;
    step();
    total++;
    if (imemReqOut !== 1'b0) $display("FAIL reset_to_idle req=%b want 0", imemReqOut);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall();
    test_wrap_illegal();
    test_halt();
    test_reset_midfetch();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
